// File: rtl/hazard_if.sv
// Pipeline-control bundle between the hazard controller (master) and the
// pipeline datapath (slave): hazard inputs from ID/EX/MEM, enable/flush pins out.
interface hazard_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  id_ex_rd;
  logic        id_ex_mem_read;
  logic        id_ex_is_mdu;
  logic        mdu_done;
  logic        ex_branch_taken;
  logic        dmem_req;
  logic        dmem_ready;

  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        mem_wb_flush;
  logic        mdu_start;
  logic        mdu_timeout;
  logic [31:0] stall_cycles;

  modport master (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd, id_ex_mem_read,
           id_ex_is_mdu, mdu_done, ex_branch_taken, dmem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           ex_mem_flush, mem_wb_flush, mdu_start, mdu_timeout, stall_cycles
  );

  modport slave (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd, id_ex_mem_read,
           id_ex_is_mdu, mdu_done, ex_branch_taken, dmem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           ex_mem_flush, mem_wb_flush, mdu_start, mdu_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: decides per cycle which pipeline registers
// advance, hold or take a bubble (load-use, MDU occupancy, dmem waits, branches).
module hazard_controller #(
  parameter int unsigned MDU_TIMEOUT = 64
) (
  input logic      clk,
  input logic      rst,
  hazard_if.master hz
);

  localparam int CW = $clog2(MDU_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MDU_WAIT, MEM_WAIT} state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
    logic mdu_start;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN         = ctrl_t'(9'b1111_0000_0);
  localparam ctrl_t CTRL_RESET       = ctrl_t'(9'b0000_1111_0);
  localparam ctrl_t CTRL_MEM_FREEZE  = ctrl_t'(9'b0000_0001_0);
  localparam ctrl_t CTRL_MDU_LAUNCH  = ctrl_t'(9'b0001_0010_1);
  localparam ctrl_t CTRL_MDU_HOLD    = ctrl_t'(9'b0001_0010_0);
  localparam ctrl_t CTRL_MDU_RELEASE = ctrl_t'(9'b0001_0100_0);
  localparam ctrl_t CTRL_BRANCH      = ctrl_t'(9'b1111_1100_0);
  localparam ctrl_t CTRL_LOAD_USE    = ctrl_t'(9'b0011_0100_0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   stall_q, stall_d;
  logic          timeout_q, timeout_d;
  ctrl_t         ctrl;
  logic          load_use;
  logic          mdu_limit;

  // x0 is hard-wired, so a load targeting it never creates a dependency.
  assign load_use = hz.id_ex_mem_read && (hz.id_ex_rd != 5'd0) &&
                    ((hz.id_uses_rs1 && (hz.id_rs1 == hz.id_ex_rd)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2 == hz.id_ex_rd)));

  // cnt_q counts completed wait cycles, so this is the MDU_TIMEOUT-th one.
  assign mdu_limit = (cnt_q == CW'(MDU_TIMEOUT - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned; otherwise synthesis infers a latch.
    ctrl      = CTRL_RUN;
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;

    unique case (state_q)
      RUN: begin
        if (hz.dmem_req && !hz.dmem_ready) begin
          ctrl    = CTRL_MEM_FREEZE;
          state_d = MEM_WAIT;
        end else if (hz.id_ex_is_mdu) begin
          ctrl    = CTRL_MDU_LAUNCH;
          cnt_d   = '0;
          state_d = MDU_WAIT;
        end else if (hz.ex_branch_taken) begin
          ctrl = CTRL_BRANCH;
        end else if (load_use) begin
          ctrl = CTRL_LOAD_USE;
        end
      end

      MEM_WAIT: begin
        // Release cycle uses plain RUN outputs; deferred work is seen next cycle.
        if (!hz.dmem_ready) ctrl    = CTRL_MEM_FREEZE;
        else                state_d = RUN;
      end

      MDU_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (hz.mdu_done || mdu_limit) begin
          ctrl    = CTRL_MDU_RELEASE;
          state_d = RUN;
          if (!hz.mdu_done) timeout_d = 1'b1;
        end else begin
          ctrl = CTRL_MDU_HOLD;
        end
      end

      default: state_d = RUN;
    endcase

    if (rst) ctrl = CTRL_RESET;

    stall_d = (!ctrl.pc_en && (stall_q != '1)) ? stall_q + 32'd1 : stall_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign hz.pc_en        = ctrl.pc_en;
  assign hz.if_id_en     = ctrl.if_id_en;
  assign hz.id_ex_en     = ctrl.id_ex_en;
  assign hz.ex_mem_en    = ctrl.ex_mem_en;
  assign hz.if_id_flush  = ctrl.if_id_flush;
  assign hz.id_ex_flush  = ctrl.id_ex_flush;
  assign hz.ex_mem_flush = ctrl.ex_mem_flush;
  assign hz.mem_wb_flush = ctrl.mem_wb_flush;
  assign hz.mdu_start    = ctrl.mdu_start;
  assign hz.mdu_timeout  = timeout_q;
  assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: constant vector table, directed
// multi-cycle sequences, and random stimulus against a behavioural model.
module tb_hazard_controller;

  localparam int TO = 4;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
    logic mdu_start;
  } ctrl_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       mdu;
    logic       done;
    logic       br;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct {
    in_t   i;
    ctrl_t e;
    string name;
  } vec_t;

  localparam ctrl_t C_DEF    = ctrl_t'(9'b1111_0000_0);
  localparam ctrl_t C_RST    = ctrl_t'(9'b0000_1111_0);
  localparam ctrl_t C_LU     = ctrl_t'(9'b0011_0100_0);
  localparam ctrl_t C_BR     = ctrl_t'(9'b1111_1100_0);
  localparam ctrl_t C_MEMF   = ctrl_t'(9'b0000_0001_0);
  localparam ctrl_t C_LAUNCH = ctrl_t'(9'b0001_0010_1);
  localparam ctrl_t C_MDUW   = ctrl_t'(9'b0001_0010_0);
  localparam ctrl_t C_REL    = ctrl_t'(9'b0001_0100_0);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  hazard_if hz();

  hazard_controller #(.MDU_TIMEOUT(TO)) u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(int rs1, int rs2, int u1, int u2, int rd,
                             int mr, int mdu, int done, int br, int req, int rdy);
    in_t r;
    r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = (u1 != 0); r.u2 = (u2 != 0);
    r.rd = 5'(rd); r.mr = (mr != 0); r.mdu = (mdu != 0); r.done = (done != 0);
    r.br = (br != 0); r.req = (req != 0); r.rdy = (rdy != 0);
    return r;
  endfunction

  function automatic ctrl_t dut_ctrl();
    return ctrl_t'({hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en,
                    hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush,
                    hz.mem_wb_flush, hz.mdu_start});
  endfunction

  // Drive one cycle's inputs after the falling edge, then settle before sampling.
  task automatic cyc(input in_t v, input logic r = 1'b0);
    @(negedge clk);
    rst                = r;
    hz.id_rs1          = v.rs1;
    hz.id_rs2          = v.rs2;
    hz.id_uses_rs1     = v.u1;
    hz.id_uses_rs2     = v.u2;
    hz.id_ex_rd        = v.rd;
    hz.id_ex_mem_read  = v.mr;
    hz.id_ex_is_mdu    = v.mdu;
    hz.mdu_done        = v.done;
    hz.ex_branch_taken = v.br;
    hz.dmem_req        = v.req;
    hz.dmem_ready      = v.rdy;
    #1;
  endtask

  task automatic step(input string name, input in_t v, input ctrl_t e, input logic r = 1'b0);
    cyc(v, r);
    check(name, 32'(dut_ctrl()), 32'(e));
  endtask

  // Behavioural model: tracks MDU occupancy by cycles waited, memory hold as a
  // flag, and the counters as plain integers.
  bit          m_mdu_busy;
  int          m_waited;
  bit          m_mem_hold;
  longint      m_stall;
  bit          m_sticky;

  function automatic ctrl_t model_step(input in_t v, input logic r);
    ctrl_t e;
    bit    lu;
    lu = v.mr && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    e  = C_DEF;
    if (r) begin
      e = C_RST;
      m_mdu_busy = 0; m_mem_hold = 0; m_stall = 0; m_sticky = 0;
      return e;
    end
    if (m_mdu_busy) begin
      m_waited++;
      if (v.done || m_waited == TO) begin
        e = C_REL;
        m_mdu_busy = 0;
        if (!v.done) m_sticky = 1;
      end else begin
        e = C_MDUW;
      end
    end else if (m_mem_hold) begin
      if (!v.rdy) e = C_MEMF;
      else        m_mem_hold = 0;
    end else if (v.req && !v.rdy) begin
      e = C_MEMF; m_mem_hold = 1;
    end else if (v.mdu) begin
      e = C_LAUNCH; m_mdu_busy = 1; m_waited = 0;
    end else if (v.br) begin
      e = C_BR;
    end else if (lu) begin
      e = C_LU;
    end
    if (!e.pc_en && m_stall < 64'hFFFF_FFFF) m_stall++;
    return e;
  endfunction

  initial begin
    vec_t  tbl[$];
    in_t   idle, v;
    ctrl_t e;
    logic  r;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset behaviour
    step("reset_outputs", idle, C_RST, 1'b1);
    step("post_reset_run", idle, C_DEF);
    check("post_reset_stall", hz.stall_cycles, 32'd0);
    check("post_reset_timeout", 32'(hz.mdu_timeout), 32'd0);

    // Single-cycle RUN decisions
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), C_DEF, "idle"});
    tbl.push_back('{mk(3, 5, 0, 1, 5, 1, 0, 0, 0, 0, 1), C_LU,  "lu_rs2"});
    tbl.push_back('{mk(7, 2, 1, 0, 7, 1, 0, 0, 0, 0, 1), C_LU,  "lu_rs1"});
    tbl.push_back('{mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1), C_DEF, "lu_rd_zero"});
    tbl.push_back('{mk(9, 5, 1, 0, 5, 1, 0, 0, 0, 0, 1), C_DEF, "lu_unused_src"});
    tbl.push_back('{mk(5, 5, 1, 1, 5, 0, 0, 0, 0, 0, 1), C_DEF, "match_not_load"});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), C_BR,  "branch"});
    tbl.push_back('{mk(4, 4, 1, 1, 4, 1, 0, 0, 1, 0, 1), C_BR,  "branch_over_lu"});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), C_DEF, "dmem_ready_hit"});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), C_DEF, "stray_mdu_done"});
    foreach (tbl[k]) step(tbl[k].name, tbl[k].i, tbl[k].e);

    // Load-use costs one bubble
    step("rst_a", idle, C_RST, 1'b1);
    step("lu_once", mk(1, 5, 0, 1, 5, 1, 0, 0, 0, 0, 1), C_LU);
    step("lu_after", idle, C_DEF);
    check("lu_stall_count", hz.stall_cycles, 32'd1);

    // MDU done on third wait cycle; branch/dmem ignored while waiting
    step("rst_b", idle, C_RST, 1'b1);
    step("mdu_launch", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), C_LAUNCH);
    step("mdu_wait1", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), C_MDUW);
    step("mdu_wait2_ignored", mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0), C_MDUW);
    step("mdu_done3", mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1), C_REL);
    step("mdu_back_run", idle, C_DEF);
    check("mdu_stall_count", hz.stall_cycles, 32'd4);
    check("mdu_no_timeout", 32'(hz.mdu_timeout), 32'd0);

    // Done coinciding with the timeout limit is a normal completion
    step("rst_c", idle, C_RST, 1'b1);
    step("tie_launch", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), C_LAUNCH);
    for (int k = 1; k < TO; k++) step("tie_wait", idle, C_MDUW);
    step("tie_done", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), C_REL);
    step("tie_run", idle, C_DEF);
    check("tie_no_timeout", 32'(hz.mdu_timeout), 32'd0);

    // Timeout without done; flag is sticky until reset
    step("to_launch", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), C_LAUNCH);
    for (int k = 1; k < TO; k++) step("to_wait", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), C_MDUW);
    check("to_flag_not_early", 32'(hz.mdu_timeout), 32'd0);
    step("to_release", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), C_REL);
    step("to_run", idle, C_DEF);
    check("to_flag_set", 32'(hz.mdu_timeout), 32'd1);
    for (int k = 0; k < 5; k++) step("to_idle", idle, C_DEF);
    check("to_flag_sticky", 32'(hz.mdu_timeout), 32'd1);

    // Reset in MDU_WAIT abandons the MDU and clears everything
    step("rst_launch", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), C_LAUNCH);
    step("rst_wait1", idle, C_MDUW);
    step("rst_mid_mdu", idle, C_RST, 1'b1);
    step("rst_mdu_run", idle, C_DEF);
    check("rst_mdu_stall", hz.stall_cycles, 32'd0);
    check("rst_mdu_timeout", 32'(hz.mdu_timeout), 32'd0);

    // Memory stall with a deferred branch held in EX
    step("mem_freeze1", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), C_MEMF);
    step("mem_freeze2", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), C_MEMF);
    step("mem_freeze3", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), C_MEMF);
    step("mem_release", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), C_DEF);
    step("mem_deferred_br", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), C_BR);
    check("mem_stall_count", hz.stall_cycles, 32'd3);

    // Randomised run against the behavioural model
    step("rand_reset", idle, C_RST, 1'b1);
    m_mdu_busy = 0; m_mem_hold = 0; m_stall = 0; m_sticky = 0; m_waited = 0;
    for (int n = 0; n < 4000; n++) begin
      v.rs1  = 5'($urandom_range(0, 3));
      v.rs2  = 5'($urandom_range(0, 3));
      v.u1   = 1'($urandom_range(0, 1));
      v.u2   = 1'($urandom_range(0, 1));
      v.rd   = 5'($urandom_range(0, 3));
      v.mr   = 1'($urandom_range(0, 1));
      v.mdu  = ($urandom_range(0, 7) == 0);
      v.done = ($urandom_range(0, 5) == 0);
      v.br   = ($urandom_range(0, 5) == 0);
      v.req  = ($urandom_range(0, 2) == 0);
      v.rdy  = 1'($urandom_range(0, 1));
      r      = ($urandom_range(0, 299) == 0);
      cyc(v, r);
      check("rand_stall", hz.stall_cycles, 32'(m_stall));
      check("rand_timeout", 32'(hz.mdu_timeout), 32'(m_sticky));
      e = model_step(v, r);
      check("rand_ctrl", 32'(dut_ctrl()), 32'(e));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the 5-stage core. It decides each cycle which pipeline registers advance, hold or take a bubble. It covers load-use hazards that bypassing cannot resolve, multi-cycle mul/div (MDU) occupancy of EX, data-memory wait states and taken-branch redirects. It sits beside the forwarding logic, consumes ID/EX and EX/MEM control fields, and drives the enable/flush pins of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- MDU_TIMEOUT, 64: max cycles in MDU_WAIT before forced release (≥2)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads that source
- id_ex_rd  in  5  destination of instruction in EX
- id_ex_mem_read  in  1  EX instruction is a load
- id_ex_is_mdu  in  1  EX instruction is a multi-cycle mul/div
- mdu_done  in  1  MDU result valid this cycle
- ex_branch_taken  in  1  EX resolved taken branch/jump
- dmem_req  in  1  MEM stage access active
- dmem_ready  in  1  data memory completes access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register loads when 1, holds when 0
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble; overrides en
- mdu_start  out  1  one-cycle MDU launch pulse
- mdu_timeout  out  1  sticky error flag
- stall_cycles  out  32  count of cycles with pc_en=0, saturating

## Operation
- States: RUN, MDU_WAIT, MEM_WAIT. Reset state is RUN.
- Default (RUN, no condition): all *_en=1, all flush=0, mdu_start=0.
- Conditions are evaluated in priority order; only the highest active one applies.
- In RUN:
  1. Memory stall, when dmem_req && !dmem_ready:
     - pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_flush=1
     - next state MEM_WAIT
     - branch and MDU requests are deferred; they stay valid because EX is held.
  2. MDU launch, when id_ex_is_mdu:
     - mdu_start=1
     - pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1
     - clear timeout counter; next state MDU_WAIT
  3. Taken branch, when ex_branch_taken:
     - pc_en=1, if_id_flush=1, id_ex_flush=1
     - the load-use check is suppressed.
  4. Load-use hazard, when id_ex_mem_read && id_ex_rd!=0 && ((id_uses_rs1 && id_rs1==id_ex_rd) || (id_uses_rs2 && id_rs2==id_ex_rd)):
     - pc_en=if_id_en=0, id_ex_flush=1
- In MEM_WAIT:
  - While !dmem_ready: hold the same freeze outputs.
  - When dmem_ready: release. Apply RUN-default outputs this cycle with no re-evaluation of branch or MDU, then go to RUN.
  - Deferred conditions are evaluated in the following RUN cycle.
- In MDU_WAIT:
  - pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1; dmem_req and ex_branch_taken are ignored.
  - Counter increments each cycle.
  - When mdu_done: ex_mem_en=1, ex_mem_flush=0, id_ex_flush=1 (EX is vacated), pc_en=if_id_en=0, then go to RUN.
  - If the counter reaches MDU_TIMEOUT without mdu_done: set mdu_timeout=1 and release exactly as for done.
  - mdu_done and timeout in the same cycle count as a normal done; mdu_timeout stays 0.
- mdu_start is never asserted outside the RUN launch cycle. A second id_ex_is_mdu is only recognised after EX reloads.
- stall_cycles increments in every cycle with pc_en=0 outside reset; it holds at 0xFFFF_FFFF.
- mdu_timeout is cleared only by rst.

## Timing
- All pipeline-control outputs are combinational from state and inputs. The state register, timeout counter, stall_cycles and mdu_timeout update on the rising clk edge.
- While rst=1: all *_en=0, all flush=1, mdu_start=0. On the next edge: state=RUN, counter=0, stall_cycles=0, mdu_timeout=0.
- Reset asserted mid-MDU_WAIT or mid-MEM_WAIT returns to RUN on the next edge; any MDU in flight is abandoned.
- Load-use costs exactly 1 bubble.
- Memory stall costs N cycles for N cycles of !dmem_ready.
- MDU with done on wait cycle k costs k+1 frozen front-end cycles (launch cycle plus k).
- Taken branch costs 2 flushed slots and no stall.

## Test plan
- Load-use: id_ex_mem_read=1, id_ex_rd=5, id_rs2=5, id_uses_rs2=1 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1.
- Load-use case with id_ex_rd=0, or a match on an unused source → no stall.
- MDU with mdu_done on the 3rd MDU_WAIT cycle → mdu_start is a single pulse, front end is frozen 4 cycles, ex_mem_flush=1 until the done cycle, then RUN.
- MDU_TIMEOUT=4 with mdu_done never asserted → release after 4 wait cycles, mdu_timeout=1 and stays 1 until rst.
- dmem_ready=0 for 3 cycles with ex_branch_taken=1 held → 3 freeze cycles with mem_wb_flush=1, 1 release cycle, then if_id_flush=id_ex_flush=1 in the next cycle.
- Branch and load-use in the same cycle → only the flushes apply, pc_en=1; rst pulsed in MDU_WAIT → RUN next cycle, stall_cycles=0.
